// File: rtl/subneg_pkg.sv
// subneg_pkg: shared state encoding and memory-mapped I/O offsets for the subneg core
package subneg_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, READ, EXEC, HALT} state_t;
    localparam int OUT_OFS = 1;
    localparam int IN_OFS  = 2;
endpackage

// File: rtl/subneg_mem.sv
// subneg_mem: DEPTH x DATA_W register file, three async read ports and one write port
module subneg_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;
    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
endmodule

// File: rtl/subneg_core_p.sv
// subneg_core_p: parametrised SUBNEG core, 3 cycles per instruction, run-time loadable memory
module subneg_core_p
    import subneg_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int OUT_ADDR   = 2**ADDR_W - OUT_OFS,
    parameter int IN_ADDR    = 2**ADDR_W - IN_OFS,
    parameter int SIGNED_CMP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);
    localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IN_ADDR);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_c, ra0, ra1, ra2, wa;
    logic [DATA_W-1:0] val_a, val_b, rd0, rd1, rd2, wd, res, src_a, src_b;
    logic              idle_ld, we, taken, hit_halt;

    assign idle_ld  = load_we && (state == IDLE || state == HALT);
    // READ reuses the first two fetch ports for the operand addresses
    assign ra0      = state == READ ? addr_a : pc;
    assign ra1      = state == READ ? addr_b : pc + ADDR_W'(1);
    assign ra2      = pc + ADDR_W'(2);
    assign src_a    = addr_a == IN_A ? in_data : addr_a == OUT_A ? out_data : rd0;
    assign src_b    = addr_b == IN_A ? in_data : addr_b == OUT_A ? out_data : rd1;
    assign res      = val_b - val_a;
    assign taken    = SIGNED_CMP != 0 ? $signed(val_a) > $signed(val_b) : val_a > val_b;
    assign hit_halt = taken && addr_c == pc;
    assign we       = idle_ld || (state == EXEC && addr_b != OUT_A && addr_b != IN_A);
    assign wa       = idle_ld ? load_addr : addr_b;
    assign wd       = idle_ld ? load_data : res;
    assign busy     = state == FETCH || state == READ || state == EXEC;
    assign halted   = state == HALT;

    subneg_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk(clk), .ra0(ra0), .ra1(ra1), .ra2(ra2),
        .rd0(rd0), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = load_we ? IDLE : (run || step) ? FETCH : IDLE;
            FETCH:   state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = hit_halt ? HALT : run ? FETCH : IDLE;
            HALT:    state_nxt = load_we ? IDLE : HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            addr_a    <= '0;
            addr_b    <= '0;
            addr_c    <= '0;
            val_a     <= '0;
            val_b     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            if (idle_ld) pc <= '0;
            if (state == FETCH) begin
                addr_a <= rd0[ADDR_W-1:0];
                addr_b <= rd1[ADDR_W-1:0];
                addr_c <= rd2[ADDR_W-1:0];
            end
            if (state == READ) begin
                val_a <= src_a;
                val_b <= src_b;
            end
            if (state == EXEC) begin
                if (addr_b == OUT_A) begin
                    out_data  <= res;
                    out_valid <= 1'b1;
                end
                if (!hit_halt) pc <= taken ? addr_c : pc + ADDR_W'(3);
            end
        end
    end
endmodule

// File: tb/tb_subneg_core_p.sv
// tb_subneg_core_p: unsigned and signed cores side by side against an instruction-level model
module tb_subneg_core_p;
    localparam int D = 32;
    logic       clk = 0, rst_n = 0, run = 0, step = 0, load_we = 0;
    logic [4:0] load_addr = '0;
    logic [7:0] load_data = '0, in_data = '0;
    logic [7:0] out_data [2];
    logic       out_valid [2], busy [2], halted [2];
    logic [4:0] pc [2];
    int         n_chk = 0, n_pass = 0;
    int         m [2][D];
    int         mo [2], mpc [2];
    bit         mh [2];

    always #5 clk = ~clk;

    subneg_core_p #(.SIGNED_CMP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .in_data(in_data),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .pc(pc[0]),
        .busy(busy[0]), .halted(halted[0])
    );
    subneg_core_p #(.SIGNED_CMP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .in_data(in_data),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .pc(pc[1]),
        .busy(busy[1]), .halted(halted[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int rdv(int i, int a);
        return a == 30 ? int'(in_data) : a == 31 ? mo[i] : m[i][a];
    endfunction

    // executes one instruction on the model; returns the number of expected out_valid pulses
    function automatic int mexec(int i);
        int a, b, c, va, vb, r, sa, sb;
        bit t;
        a  = m[i][mpc[i]] % D;
        b  = m[i][(mpc[i] + 1) % D] % D;
        c  = m[i][(mpc[i] + 2) % D] % D;
        va = rdv(i, a);
        vb = rdv(i, b);
        r  = (vb - va + 256) % 256;
        sa = va >= 128 ? va - 256 : va;
        sb = vb >= 128 ? vb - 256 : vb;
        t  = i == 1 ? sa > sb : va > vb;
        if (b == 31) mo[i] = r;
        else if (b != 30) m[i][b] = r;
        if (t && c == mpc[i]) mh[i] = 1;
        else mpc[i] = t ? c : (mpc[i] + 3) % D;
        return b == 31 ? 1 : 0;
    endfunction

    task automatic load(input int a, input int d);
        @(negedge clk);
        load_we = 1; load_addr = 5'(a); load_data = 8'(d);
        @(negedge clk);
        load_we = 0;
        for (int i = 0; i < 2; i++) begin m[i][a] = d; mpc[i] = 0; mh[i] = 0; end
    endtask

    task automatic do_reset(input bit check);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        if (check)
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rst out_data[%0d]", i), out_data[i], 0);
                chk($sformatf("rst out_valid[%0d]", i), out_valid[i], 0);
                chk($sformatf("rst pc[%0d]", i), pc[i], 0);
                chk($sformatf("rst busy[%0d]", i), busy[i], 0);
                chk($sformatf("rst halted[%0d]", i), halted[i], 0);
            end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin mo[i] = 0; mpc[i] = 0; mh[i] = 0; end
    endtask

    task automatic do_step(input string tag);
        int bc [2], vc [2], eb [2], ev [2];
        for (int i = 0; i < 2; i++) begin
            eb[i] = mh[i] ? 0 : 3;
            ev[i] = mh[i] ? 0 : mexec(i);
            bc[i] = 0; vc[i] = 0;
        end
        @(negedge clk);
        step = 1;
        repeat (5) begin
            @(negedge clk);
            step = 0;
            for (int i = 0; i < 2; i++) begin bc[i] += int'(busy[i]); vc[i] += int'(out_valid[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s busy_cycles[%0d]", tag, i), bc[i], eb[i]);
            chk($sformatf("%s out_valid_pulses[%0d]", tag, i), vc[i], ev[i]);
            chk($sformatf("%s pc[%0d]", tag, i), pc[i], mpc[i]);
            chk($sformatf("%s out_data[%0d]", tag, i), out_data[i], mo[i]);
            chk($sformatf("%s halted[%0d]", tag, i), halted[i], mh[i]);
        end
    endtask

    task automatic load_demo();
        int prog [9] = '{8, 31, 3, 7, 6, 3, 0, 1, 5};
        for (int k = 0; k < 9; k++) load(k, prog[k]);
    endtask

    initial begin
        int cyc, bc, vc;
        #3;
        chk("por pc", pc[0], 0);
        chk("por busy", busy[0], 0);
        chk("por halted", halted[0], 0);
        chk("por out_data", out_data[0], 0);
        @(negedge clk);
        rst_n = 1;

        // free run until halt
        load_demo();
        @(negedge clk);
        run = 1;
        cyc = 0; bc = 0; vc = 0;
        while (!(halted[0] && halted[1]) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bc += int'(busy[0]);
            if (out_valid[0]) begin
                vc++;
                chk("run first out_data", out_data[0], 251);
                chk("run first pc", pc[0], 3);
            end
        end
        run = 0;
        for (int i = 0; i < 2; i++) begin void'(mexec(i)); void'(mexec(i)); end
        chk("run halted0", halted[0], 1);
        chk("run halted1", halted[1], 1);
        chk("run pc", pc[0], 3);
        chk("run busy_cycles", bc, 6);
        chk("run out_valid_pulses", vc, 1);
        chk("run mem6", dut0.u_mem.mem[6], 255);
        chk("run model pc1", pc[1], mpc[1]);

        do_reset(1);

        // single stepping
        load_demo();
        do_step("step1");
        chk("step1 out_data", out_data[0], 251);
        chk("step1 pc", pc[0], 3);
        do_step("step2");
        chk("step2 halted", halted[0], 1);
        do_step("step_in_halt");
        load(9, 5);
        chk("halt load pc", pc[0], 0);
        chk("halt load halted", halted[0], 0);
        chk("halt load busy", busy[0], 0);

        // input port
        do_reset(0);
        in_data = 10;
        load(0, 30); load(1, 31); load(2, 0);
        do_step("inport");
        chk("inport out_data", out_data[0], 246);
        chk("inport pc", pc[0], 0);

        // signed vs unsigned compare
        do_reset(0);
        load(10, 8'h7F); load(11, 8'h80); load(0, 10); load(1, 11); load(2, 20);
        do_step("cmp");
        chk("cmp unsigned pc", pc[0], 3);
        chk("cmp signed pc", pc[1], 20);
        chk("cmp res0", dut0.u_mem.mem[11], 1);
        chk("cmp res1", dut1.u_mem.mem[11], 1);

        // reset during EXEC and load while busy
        do_reset(0);
        load_demo();
        do_step("pre_exec");
        @(negedge clk);
        step = 1;
        @(negedge clk);
        step = 0; load_we = 1; load_addr = 0; load_data = 99;
        @(negedge clk);
        @(negedge clk);
        load_we = 0;
        rst_n = 0;
        #1;
        chk("exec_rst pc", pc[0], 0);
        chk("exec_rst mem6", dut0.u_mem.mem[6], 0);
        chk("busy_load mem0", dut0.u_mem.mem[0], 8);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin mo[i] = 0; mpc[i] = 0; mh[i] = 0; end
        do_step("rerun");
        chk("rerun out_data", out_data[0], 251);

        // randomized programs, single-stepped
        for (int t = 0; t < 20; t++) begin
            do_reset(0);
            in_data = 8'($urandom);
            for (int a = 0; a < D; a++) load(a, int'($urandom_range(0, 255)));
            for (int s = 0; s < 6; s++) begin
                if ($urandom_range(0, 3) == 0) in_data = 8'($urandom);
                do_step($sformatf("rnd%0d.%0d", t, s));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
